// File: rtl/alu_writeback_seq.sv
// rtl/alu_writeback_seq.sv - ALU result writeback sequencer with per-thread pending scoreboard
// Optional retire counter port o_retire_count is enabled by defining ALU_WB_RETIRE_COUNT_EN.
module alu_writeback_seq #(
  parameter int DWIDTH        = 32,
  parameter int NUM_THREADS   = 16,
  parameter int TID_WIDTH     = $clog2(NUM_THREADS),
  parameter int REGADDR_WIDTH = 5,
  parameter int ALU_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_issue_valid,
  input  logic [TID_WIDTH-1:0]     i_issue_tid,
  input  logic [REGADDR_WIDTH-1:0] i_issue_rd,
  input  logic                     i_issue_we,
  input  logic [DWIDTH-1:0]        i_alu_result,
  input  logic                     i_flush_valid,
  input  logic [TID_WIDTH-1:0]     i_flush_tid,
  output logic                     o_rf_we,
  output logic [TID_WIDTH-1:0]     o_rf_tid,
  output logic [REGADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DWIDTH-1:0]        o_rf_wdata,
  output logic [NUM_THREADS-1:0]   o_pending,
`ifdef ALU_WB_RETIRE_COUNT_EN
  output logic [31:0]              o_retire_count,
`endif
  output logic                     o_busy
);

  if (ALU_LATENCY < 0 || ALU_LATENCY > 3) begin : g_bad_latency
    $error("alu_writeback_seq: ALU_LATENCY must be in 0..3");
  end
  if ((1 << TID_WIDTH) != NUM_THREADS || NUM_THREADS < 2) begin : g_bad_threads
    $error("alu_writeback_seq: NUM_THREADS must be a power of 2 and >= 2");
  end

  logic                     issue_tag_valid;
  logic                     issue_killed;
  logic                     al_valid;
  logic [TID_WIDTH-1:0]     al_tid;
  logic [REGADDR_WIDTH-1:0] al_rd;
  logic                     al_keep;
  logic [NUM_THREADS-1:0]   pipe_pending;

  // x0 is hardwired zero, so writes to it are never tracked
  assign issue_tag_valid = i_issue_valid & i_issue_we & (i_issue_rd != '0);
  assign issue_killed    = i_flush_valid & (i_issue_tid == i_flush_tid);

  if (ALU_LATENCY == 0) begin : g_nopipe
    assign al_valid     = issue_tag_valid;
    assign al_tid       = i_issue_tid;
    assign al_rd        = i_issue_rd;
    assign pipe_pending = '0;
  end else begin : g_pipe
    logic                     stg_valid [ALU_LATENCY];
    logic [TID_WIDTH-1:0]     stg_tid   [ALU_LATENCY];
    logic [REGADDR_WIDTH-1:0] stg_rd    [ALU_LATENCY];

    // Each stage drops its tag on the way to the next stage if its thread is flushed
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < ALU_LATENCY; i++) begin
          stg_valid[i] <= 1'b0;
          stg_tid[i]   <= '0;
          stg_rd[i]    <= '0;
        end
      end else begin
        stg_valid[0] <= issue_tag_valid & ~issue_killed;
        stg_tid[0]   <= i_issue_tid;
        stg_rd[0]    <= i_issue_rd;
        for (int i = 1; i < ALU_LATENCY; i++) begin
          stg_valid[i] <= stg_valid[i-1] & ~(i_flush_valid & (stg_tid[i-1] == i_flush_tid));
          stg_tid[i]   <= stg_tid[i-1];
          stg_rd[i]    <= stg_rd[i-1];
        end
      end
    end

    assign al_valid = stg_valid[ALU_LATENCY-1];
    assign al_tid   = stg_tid[ALU_LATENCY-1];
    assign al_rd    = stg_rd[ALU_LATENCY-1];

    always_comb begin
      pipe_pending = '0;
      for (int i = 0; i < ALU_LATENCY; i++) begin
        if (stg_valid[i]) pipe_pending[stg_tid[i]] = 1'b1;
      end
    end
  end

  assign al_keep = al_valid & ~(i_flush_valid & (al_tid == i_flush_tid));

  // Address/data only move on a real write so they stay stable while o_rf_we is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_tid   <= '0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_we <= al_keep;
      if (al_keep) begin
        o_rf_tid   <= al_tid;
        o_rf_waddr <= al_rd;
        o_rf_wdata <= i_alu_result;
      end
    end
  end

  always_comb begin
    o_pending = pipe_pending;
    if (o_rf_we) o_pending[o_rf_tid] = 1'b1;
  end

  assign o_busy = |o_pending;

`ifdef ALU_WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_retire_count <= '0;
    end else if (o_rf_we) begin
      o_retire_count <= o_retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_writeback_seq.sv
// tb/tb_alu_writeback_seq.sv - scoreboard bench driving four DUTs with ALU_LATENCY 0..3 in lockstep
module tb_alu_writeback_seq;

  localparam int NL = 4;

  typedef struct {
    logic [3:0]  tid;
    logic [4:0]  rd;
    logic [31:0] data;
    int          issue;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_tid = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_we = 1'b0;
  logic        flush_valid = 1'b0;
  logic [3:0]  flush_tid = '0;
  logic [31:0] res [NL];

  logic        rf_we    [NL];
  logic [3:0]  rf_tid   [NL];
  logic [4:0]  rf_waddr [NL];
  logic [31:0] rf_wdata [NL];
  logic [15:0] pending  [NL];
  logic        busy     [NL];
`ifdef ALU_WB_RETIRE_COUNT_EN
  logic [31:0] rc  [NL];
  int          nwr [NL];
`endif

  ent_t        sbq [NL][$];
  logic [31:0] data_of [4096];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    alu_writeback_seq #(.ALU_LATENCY(g)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_issue_valid (issue_valid),
      .i_issue_tid   (issue_tid),
      .i_issue_rd    (issue_rd),
      .i_issue_we    (issue_we),
      .i_alu_result  (res[g]),
      .i_flush_valid (flush_valid),
      .i_flush_tid   (flush_tid),
      .o_rf_we       (rf_we[g]),
      .o_rf_tid      (rf_tid[g]),
      .o_rf_waddr    (rf_waddr[g]),
      .o_rf_wdata    (rf_wdata[g]),
      .o_pending     (pending[g]),
`ifdef ALU_WB_RETIRE_COUNT_EN
      .o_retire_count(rc[g]),
`endif
      .o_busy        (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int l = 0; l < NL; l++) begin
      logic [15:0] exp_p;
      logic        exp_we;
      exp_p = '0;
      foreach (sbq[l][i]) exp_p[sbq[l][i].tid] = 1'b1;
      exp_we = (sbq[l].size() > 0) && (sbq[l][0].issue + l + 1 == cyc);
      check($sformatf("L%0d pending", l), {16'h0, pending[l]}, {16'h0, exp_p});
      check($sformatf("L%0d busy", l), {31'h0, busy[l]}, {31'h0, |exp_p});
      check($sformatf("L%0d rf_we", l), {31'h0, rf_we[l]}, {31'h0, exp_we});
`ifdef ALU_WB_RETIRE_COUNT_EN
      check($sformatf("L%0d retire_count", l), rc[l], nwr[l]);
`endif
      if (exp_we) begin
        check($sformatf("L%0d rf_tid", l), {28'h0, rf_tid[l]}, {28'h0, sbq[l][0].tid});
        check($sformatf("L%0d rf_waddr", l), {27'h0, rf_waddr[l]}, {27'h0, sbq[l][0].rd});
        check($sformatf("L%0d rf_wdata", l), rf_wdata[l], sbq[l][0].data);
        void'(sbq[l].pop_front());
`ifdef ALU_WB_RETIRE_COUNT_EN
        nwr[l]++;
`endif
      end
    end
  endtask

  // One clock cycle: check current outputs, drive this cycle's inputs, update scoreboard, advance
  task automatic step(input logic iv, input logic [3:0] tid, input logic [4:0] rd, input logic we,
                      input logic [31:0] data, input logic fv, input logic [3:0] ftid);
    check_outputs();
    issue_valid = iv; issue_tid = tid; issue_rd = rd; issue_we = we;
    flush_valid = fv; flush_tid = ftid;
    data_of[cyc] = data;
    for (int l = 0; l < NL; l++) begin
      res[l] = (cyc >= l) ? data_of[cyc-l] : 32'h0;
      if (fv) begin
        for (int i = sbq[l].size() - 1; i >= 0; i--) begin
          if (sbq[l][i].tid == ftid && sbq[l][i].issue >= cyc - l) sbq[l].delete(i);
        end
      end
      if (iv && we && rd != 5'd0 && !(fv && tid == ftid)) begin
        ent_t e;
        e.tid = tid; e.rd = rd; e.data = data; e.issue = cyc;
        sbq[l].push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 5'd0, 1'b0, $urandom, 1'b0, 4'd0);
  endtask

  task automatic check_reset_outputs();
    for (int l = 0; l < NL; l++) begin
      check($sformatf("L%0d rst rf_we", l), {31'h0, rf_we[l]}, 32'h0);
      check($sformatf("L%0d rst rf_tid", l), {28'h0, rf_tid[l]}, 32'h0);
      check($sformatf("L%0d rst rf_waddr", l), {27'h0, rf_waddr[l]}, 32'h0);
      check($sformatf("L%0d rst rf_wdata", l), rf_wdata[l], 32'h0);
      check($sformatf("L%0d rst pending", l), {16'h0, pending[l]}, 32'h0);
      check($sformatf("L%0d rst busy", l), {31'h0, busy[l]}, 32'h0);
`ifdef ALU_WB_RETIRE_COUNT_EN
      check($sformatf("L%0d rst retire_count", l), rc[l], 32'h0);
`endif
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    issue_valid = 1'b0; flush_valid = 1'b0;
    #1;
    check_reset_outputs();
    for (int l = 0; l < NL; l++) begin
      sbq[l].delete();
`ifdef ALU_WB_RETIRE_COUNT_EN
      nwr[l] = 0;
`endif
    end
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int l = 0; l < NL; l++) res[l] = 32'h0;
    apply_reset();

    // Single tracked op with known data
    step(1'b1, 4'd3, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 4'd0);
    idle(5);

    // Untracked ops: rd=0 and we=0
    step(1'b1, 4'd6, 5'd0, 1'b1, 32'h11111111, 1'b0, 4'd0);
    step(1'b1, 4'd7, 5'd7, 1'b0, 32'h22222222, 1'b0, 4'd0);
    idle(5);

    // Back-to-back issue across all threads
    for (int t = 0; t < 16; t++) step(1'b1, t[3:0], 5'(t + 1), 1'b1, $urandom, 1'b0, 4'd0);
    idle(5);

    // Flush tid2 one cycle after its issue while tid4 issues
    step(1'b1, 4'd2, 5'd9, 1'b1, 32'hA5A5_0002, 1'b0, 4'd0);
    step(1'b1, 4'd4, 5'd10, 1'b1, 32'hA5A5_0004, 1'b1, 4'd2);
    idle(5);

    // Flush hitting a same-cycle issue of the flushed thread
    step(1'b1, 4'd8, 5'd3, 1'b1, 32'h0000_0808, 1'b1, 4'd8);
    idle(5);

    // Random traffic with collisions on a few threads
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           $urandom_range(0, 7) != 0, $urandom, $urandom_range(0, 5) == 0,
           4'($urandom_range(0, 3)));
    end
    idle(5);

    // Reset with three ops in flight
    step(1'b1, 4'd1, 5'd1, 1'b1, 32'h1, 1'b0, 4'd0);
    step(1'b1, 4'd2, 5'd2, 1'b1, 32'h2, 1'b0, 4'd0);
    step(1'b1, 4'd3, 5'd3, 1'b1, 32'h3, 1'b0, 4'd0);
    apply_reset();
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
